// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter (ALU/LD/CSR) with a per-register pending scoreboard.
// One-cycle grant-to-write latency; losers see ready=0 and must hold; rd=0 requests are accepted at once.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [WIDTH-1:0]      ld_data,
    output logic                  ld_ready,
    input  logic                  csr_valid,
    input  logic [ADDR_WIDTH-1:0] csr_rd,
    input  logic [WIDTH-1:0]      csr_data,
    output logic                  csr_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  flush,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [WIDTH-1:0]      w_data_reg_file,
    output logic [DEPTH-1:0]      pending
);

    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [WIDTH-1:0]      w_data_q;
    logic [DEPTH-1:0]      pending_q, pending_d;

    logic [2:0]            req_v;
    logic [2:0]            gnt;
    logic [ADDR_WIDTH-1:0] gnt_rd;
    logic [WIDTH-1:0]      gnt_data;

    // Only requests that actually write compete; rd=0 requests bypass arbitration.
    assign req_v = {csr_valid && (csr_rd != '0),
                    ld_valid  && (ld_rd  != '0),
                    alu_valid && (alu_rd != '0)};

    always_comb begin
        gnt = 3'b000;
        case (rr_ptr_q)
            2'd1: begin
                if      (req_v[1]) gnt = 3'b010;
                else if (req_v[2]) gnt = 3'b100;
                else if (req_v[0]) gnt = 3'b001;
            end
            2'd2: begin
                if      (req_v[2]) gnt = 3'b100;
                else if (req_v[0]) gnt = 3'b001;
                else if (req_v[1]) gnt = 3'b010;
            end
            default: begin
                if      (req_v[0]) gnt = 3'b001;
                else if (req_v[1]) gnt = 3'b010;
                else if (req_v[2]) gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        gnt_rd   = alu_rd;
        gnt_data = alu_data;
        rr_ptr_d = rr_ptr_q;
        if (gnt[0]) rr_ptr_d = 2'd1;
        if (gnt[1]) begin
            gnt_rd   = ld_rd;
            gnt_data = ld_data;
            rr_ptr_d = 2'd2;
        end
        if (gnt[2]) begin
            gnt_rd   = csr_rd;
            gnt_data = csr_data;
            rr_ptr_d = 2'd0;
        end
    end

    assign alu_ready = rst_n && alu_valid && ((alu_rd == '0) || gnt[0]);
    assign ld_ready  = rst_n && ld_valid  && ((ld_rd  == '0) || gnt[1]);
    assign csr_ready = rst_n && csr_valid && ((csr_rd == '0) || gnt[2]);

    // Issue is applied after the clear so a same-cycle set on the written register survives.
    always_comb begin
        pending_d = pending_q;
        if (flush)     pending_d = '0;
        else if (we_q) pending_d[w_addr_q] = 1'b0;
        if (iss_valid && (iss_rd != '0)) pending_d[iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= 2'd0;
            we_q      <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            pending_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= |gnt;
            pending_q <= pending_d;
            if (|gnt) begin
                w_addr_q <= gnt_rd;
                w_data_q <= gnt_data;
            end
        end
    end

    assign we              = we_q;
    assign w_addr          = w_addr_q;
    assign w_data_reg_file = w_data_q;
    assign pending         = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, rd=0 bypass, scoreboard, flush and reset.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, ld_valid, csr_valid;
    logic [AW-1:0] alu_rd, ld_rd, csr_rd;
    logic [W-1:0]  alu_data, ld_data, csr_data;
    logic          alu_ready, ld_ready, csr_ready;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          flush;
    logic          we;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_data_reg_file;
    logic [D-1:0]  pending;
    logic [2:0]    rdy;

    int checks   = 0;
    int failures = 0;

    assign rdy = {csr_ready, ld_ready, alu_ready};

    rf_wb_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .csr_valid(csr_valid), .csr_rd(csr_rd), .csr_data(csr_data), .csr_ready(csr_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .we(we), .w_addr(w_addr), .w_data_reg_file(w_data_reg_file), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic clr_inputs;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
        csr_valid = 0; csr_rd = '0; csr_data = '0;
        iss_valid = 0; iss_rd = '0; flush = 0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clr_inputs();
        alu_valid = 1; alu_rd = 5'd3;
        ld_valid  = 1; ld_rd  = 5'd0;
        repeat (2) @(posedge clk);
        mid();
        checks++; if (rdy !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", rdy); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (w_addr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", w_addr); end
        checks++; if (w_data_reg_file !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", w_data_reg_file); end
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
        clr_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA000_0003;
        ld_valid  = 1; ld_rd  = 5'd4; ld_data  = 32'hB000_0004;
        csr_valid = 1; csr_rd = 5'd5; csr_data = 32'hC000_0005;
        mid();
        checks++; if (rdy !== 3'b001) begin failures++; $display("FAIL rr_c1_ready got=%b exp=001", rdy); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rr_c1_we got=%b exp=0", we); end
        step(); alu_valid = 0;
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd3 || w_data_reg_file !== 32'hA000_0003) begin failures++; $display("FAIL rr_c2_write got=%b/%0d/%h exp=1/3/a0000003", we, w_addr, w_data_reg_file); end
        checks++; if (rdy !== 3'b010) begin failures++; $display("FAIL rr_c2_ready got=%b exp=010", rdy); end
        step(); ld_valid = 0;
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd4 || w_data_reg_file !== 32'hB000_0004) begin failures++; $display("FAIL rr_c3_write got=%b/%0d/%h exp=1/4/b0000004", we, w_addr, w_data_reg_file); end
        checks++; if (rdy !== 3'b100) begin failures++; $display("FAIL rr_c3_ready got=%b exp=100", rdy); end
        step(); csr_valid = 0;
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd5 || w_data_reg_file !== 32'hC000_0005) begin failures++; $display("FAIL rr_c4_write got=%b/%0d/%h exp=1/5/c0000005", we, w_addr, w_data_reg_file); end
        step();
        mid();
        checks++; if (we !== 1'b0 || w_addr !== 5'd5 || w_data_reg_file !== 32'hC000_0005) begin failures++; $display("FAIL rr_idle_hold got=%b/%0d/%h exp=0/5/c0000005", we, w_addr, w_data_reg_file); end
    endtask

    task automatic test_zero_rd;
        step();
        ld_valid  = 1; ld_rd  = 5'd0; ld_data  = 32'hDEAD_0000;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'hA000_0007;
        mid();
        checks++; if (rdy !== 3'b011) begin failures++; $display("FAIL zero_both_ready got=%b exp=011", rdy); end
        step(); clr_inputs();
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd7 || w_data_reg_file !== 32'hA000_0007) begin failures++; $display("FAIL zero_write got=%b/%0d/%h exp=1/7/a0000007", we, w_addr, w_data_reg_file); end
        step();
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA000_0001;
        ld_valid  = 1; ld_rd  = 5'd2; ld_data  = 32'hB000_0002;
        mid();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL zero_single_write got=%b exp=0", we); end
        checks++; if (rdy !== 3'b010) begin failures++; $display("FAIL zero_ptr_is_ld got=%b exp=010", rdy); end
        step(); ld_valid = 0;
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd2) begin failures++; $display("FAIL zero_ld_write got=%b/%0d exp=1/2", we, w_addr); end
        checks++; if (rdy !== 3'b001) begin failures++; $display("FAIL zero_alu_next got=%b exp=001", rdy); end
        step(); clr_inputs();
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd1) begin failures++; $display("FAIL zero_alu_write got=%b/%0d exp=1/1", we, w_addr); end
        step();
        ld_valid = 1; ld_rd = 5'd0; ld_data = 32'h1234_5678;
        mid();
        checks++; if (rdy !== 3'b010) begin failures++; $display("FAIL zero_alone_ready got=%b exp=010", rdy); end
        step(); clr_inputs();
        mid();
        checks++; if (we !== 1'b0 || w_addr !== 5'd1) begin failures++; $display("FAIL zero_alone_nowrite got=%b/%0d exp=0/1", we, w_addr); end
    endtask

    task automatic test_pending;
        step(); iss_valid = 1; iss_rd = 5'd9;
        mid();
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL pend_before got=%h exp=0", pending); end
        step(); iss_valid = 0;
        mid();
        checks++; if (pending !== 32'h0000_0200) begin failures++; $display("FAIL pend_set got=%h exp=00000200", pending); end
        step(); alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hA000_0009;
        mid();
        checks++; if (alu_ready !== 1'b1 || pending !== 32'h0000_0200) begin failures++; $display("FAIL pend_grant got=%b/%h exp=1/00000200", alu_ready, pending); end
        step(); clr_inputs();
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd9 || pending !== 32'h0000_0200) begin failures++; $display("FAIL pend_we_cycle got=%b/%0d/%h exp=1/9/00000200", we, w_addr, pending); end
        step();
        mid();
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL pend_cleared got=%h exp=0", pending); end
        step(); iss_valid = 1; iss_rd = 5'd9;
        step(); iss_valid = 1; iss_rd = 5'd0;
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hA100_0009;
        mid();
        checks++; if (pending !== 32'h0000_0200) begin failures++; $display("FAIL pend_reissue got=%h exp=00000200", pending); end
        step(); clr_inputs(); iss_valid = 1; iss_rd = 5'd9;
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd9 || pending !== 32'h0000_0200) begin failures++; $display("FAIL pend_r0_ignored got=%b/%0d/%h exp=1/9/00000200", we, w_addr, pending); end
        step(); clr_inputs();
        mid();
        checks++; if (pending !== 32'h0000_0200) begin failures++; $display("FAIL pend_set_wins got=%h exp=00000200", pending); end
    endtask

    task automatic test_flush;
        step(); iss_valid = 1; iss_rd = 5'd10;
        step(); iss_valid = 1; iss_rd = 5'd11;
        step(); clr_inputs(); flush = 1;
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA000_000A;
        mid();
        checks++; if (pending !== 32'h0000_0E00 || alu_ready !== 1'b1) begin failures++; $display("FAIL flush_before got=%h/%b exp=00000e00/1", pending, alu_ready); end
        step(); clr_inputs();
        mid();
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL flush_clear got=%h exp=0", pending); end
        checks++; if (we !== 1'b1 || w_addr !== 5'd10 || w_data_reg_file !== 32'hA000_000A) begin failures++; $display("FAIL flush_keeps_write got=%b/%0d/%h exp=1/10/a000000a", we, w_addr, w_data_reg_file); end
        step(); iss_valid = 1; iss_rd = 5'd12; flush = 1;
        step(); clr_inputs();
        mid();
        checks++; if (pending !== 32'h0000_1000) begin failures++; $display("FAIL flush_iss_applies got=%h exp=00001000", pending); end
    endtask

    task automatic test_reset_mid;
        step(); ld_valid = 1; ld_rd = 5'd4; ld_data = 32'hB000_0004;
        mid();
        checks++; if (rdy !== 3'b010) begin failures++; $display("FAIL rmid_ld_ready got=%b exp=010", rdy); end
        step();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA000_0003;
        csr_valid = 1; csr_rd = 5'd5; csr_data = 32'hC000_0005;
        #1;
        checks++; if (we !== 1'b1 || w_addr !== 5'd4 || rdy !== 3'b100) begin failures++; $display("FAIL rmid_pre got=%b/%0d/%b exp=1/4/100", we, w_addr, rdy); end
        rst_n = 1'b0;
        #1;
        checks++; if (we !== 1'b0 || w_addr !== 5'd0 || w_data_reg_file !== 32'h0) begin failures++; $display("FAIL rmid_outputs got=%b/%0d/%h exp=0/0/0", we, w_addr, w_data_reg_file); end
        checks++; if (pending !== 32'h0 || rdy !== 3'b000) begin failures++; $display("FAIL rmid_pend_ready got=%h/%b exp=0/000", pending, rdy); end
        mid();
        mid();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rmid_dropped got=%b exp=0", we); end
        step(); rst_n = 1'b1;
        mid();
        checks++; if (rdy !== 3'b001) begin failures++; $display("FAIL rmid_alu_first got=%b exp=001", rdy); end
        step(); alu_valid = 0;
        mid();
        checks++; if (we !== 1'b1 || w_addr !== 5'd3 || rdy !== 3'b010) begin failures++; $display("FAIL rmid_after got=%b/%0d/%b exp=1/3/010", we, w_addr, rdy); end
        step(); clr_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_zero_rd();
        test_pending();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of the register-file write port.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 alu_valid / ld_valid / csr_valid  in  1 each  writeback request from requester 0 / 1 / 2.
REQ-007 alu_rd / ld_rd / csr_rd  in  ADDR_WIDTH each  destination register.
REQ-008 alu_data / ld_data / csr_data  in  WIDTH each  write data.
REQ-009 alu_ready / ld_ready / csr_ready  out  1 each  request consumed this cycle; combinational.
REQ-010 iss_valid  in  1  instruction issued with a destination register.
REQ-011 iss_rd  in  ADDR_WIDTH  destination register of the issued instruction.
REQ-012 flush  in  1  pipeline flush; clears the pending scoreboard.
REQ-013 we  out  1  register-file write enable; registered.
REQ-014 w_addr  out  ADDR_WIDTH  register-file write address; registered.
REQ-015 w_data_reg_file  out  WIDTH  register-file write data; registered.
REQ-016 pending  out  DEPTH  per-register outstanding-write bit; registered.

Function
REQ-017 A request SHALL be consumed in any cycle where valid and ready are both 1; the requester SHALL hold rd/data stable while valid=1 and ready=0.
REQ-018 A request with rd=0 SHALL be consumed in its first valid cycle (ready=1) without arbitration, without a write, and without moving the round-robin pointer.
REQ-019 Among the valid requests with rd!=0, exactly one SHALL be granted per cycle, in round-robin order starting at rr_ptr (0=ALU, 1=LD, 2=CSR).
REQ-020 After a grant to index i, rr_ptr SHALL become (i+1) mod 3 at the next edge; with no grant, rr_ptr SHALL hold.
REQ-021 Latency SHALL be one cycle: a grant in cycle k SHALL drive we=1, w_addr=rd, w_data_reg_file=data in cycle k+1.
REQ-022 In a cycle with no grant, we SHALL be 0 at the next edge; w_addr and w_data_reg_file SHALL hold their previous values.
REQ-023 we=1 with w_addr=0 SHALL never occur.
REQ-024 On iss_valid=1 with iss_rd!=0, pending[iss_rd] SHALL be set at the next edge.
REQ-025 In a cycle with we=1, pending[w_addr] SHALL be cleared at the next edge.
REQ-026 If set and clear target the same register in the same cycle, set SHALL win.
REQ-027 An issue to a register that is already pending SHALL leave the bit set; at most one outstanding write per register is supported.
REQ-028 pending[0] SHALL always read 0.
REQ-029 flush=1 SHALL clear all pending bits at the next edge; a simultaneous iss_valid set SHALL still apply.
REQ-030 flush SHALL NOT cancel an already granted write: we in the following cycle is still issued.
REQ-031 Ready outputs SHALL depend only on the valid/rd inputs and rr_ptr, with no combinational path from we or pending.

Reset
REQ-032 While rst_n=0: we=0, w_addr=0, w_data_reg_file=0, pending=0, rr_ptr=0, and all ready outputs=0.
REQ-033 Assertion of rst_n mid-operation SHALL take effect immediately; a write granted in the cycle reset asserts SHALL be dropped.
REQ-034 The first grant after reset release SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-035 After reset, ALU, LD and CSR all valid with rd=3, 4, 5 held -> grants in order ALU, LD, CSR on consecutive cycles; we=1 with w_addr 3, 4, 5 in cycles 2, 3, 4.
REQ-036 ld_valid with rd=0 concurrent with alu_valid with rd=7 -> ld_ready=1 and alu_ready=1 in the same cycle; one write only (w_addr=7); rr_ptr=1 afterwards.
REQ-037 iss_valid with iss_rd=9; two cycles later alu writes rd=9 -> pending[9]=1 until the edge after we=1 with w_addr=9, then 0.
REQ-038 In the cycle with we=1 and w_addr=9, iss_valid with iss_rd=9 -> pending[9] stays 1.
REQ-039 pending={10,11} set, flush=1 while a grant for rd=10 is in flight -> pending=0 next edge; we=1 with w_addr=10 still occurs.
REQ-040 rst_n pulled low during a cycle with 3 valid requests -> outputs zero immediately; after release, ALU is granted first.
